// File: rtl/sha256_nonce_scheduler.sv
// Walks a nonce range through one single-block SHA-256 core and compares each digest against a target.
// Each nonce costs core latency + 2 cycles; the config handshake is only taken while idle or after a sweep ends.
module sha256_nonce_scheduler #(
  parameter int NONCE_LSB      = 384,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [511:0] cfg_template,
  input  logic [255:0] cfg_target,
  input  logic [31:0]  cfg_nonce_start,
  input  logic [31:0]  cfg_nonce_end,
  input  logic         abort,
  output logic         core_start,
  output logic [511:0] core_block,
  input  logic         core_done,
  input  logic [255:0] core_hash,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout_err,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic [31:0]  hash_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CHECK, S_FOUND, S_EXH, S_TERR
  } state_t;

  state_t state, state_nxt;

  logic [511:0]    tmpl;
  logic [255:0]    target;
  logic [31:0]     nonce;
  logic [31:0]     nonce_end;
  logic [31:0]     nonce_nxt;
  logic [WD_W-1:0] wdog;
  logic            abort_pend;
  logic            rest, accept, hit, abort_now, wd_expire, last_nonce;

  function automatic logic [511:0] insert_nonce(input logic [511:0] blk, input logic [31:0] n);
    logic [511:0] b;
    b = blk;
    b[NONCE_LSB +: 32] = n;
    return b;
  endfunction

  assign rest        = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXH) || (state == S_TERR);
  assign cfg_ready   = rest;
  assign busy        = !rest;
  assign core_start  = (state == S_START);
  assign found       = (state == S_FOUND);
  assign exhausted   = (state == S_EXH);
  assign timeout_err = (state == S_TERR);

  assign accept     = cfg_valid && rest;
  assign hit        = result_hash < target;
  assign abort_now  = abort_pend || abort;
  assign wd_expire  = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign last_nonce = (nonce == nonce_end);
  assign nonce_nxt  = nonce + 32'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FOUND, S_EXH, S_TERR: if (cfg_valid) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      // A digest arriving on the expiry cycle still counts.
      S_WAIT: begin
        if (core_done)      state_nxt = S_CHECK;
        else if (wd_expire) state_nxt = S_TERR;
      end
      S_CHECK: begin
        if (hit)             state_nxt = S_FOUND;
        else if (abort_now)  state_nxt = S_IDLE;
        else if (last_nonce) state_nxt = S_EXH;
        else                 state_nxt = S_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      tmpl         <= '0;
      target       <= '0;
      nonce        <= '0;
      nonce_end    <= '0;
      wdog         <= '0;
      abort_pend   <= 1'b0;
      core_block   <= '0;
      result_nonce <= '0;
      result_hash  <= '0;
      hash_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        tmpl       <= cfg_template;
        target     <= cfg_target;
        nonce      <= cfg_nonce_start;
        nonce_end  <= cfg_nonce_end;
        hash_count <= '0;
        abort_pend <= 1'b0;
        core_block <= insert_nonce(cfg_template, cfg_nonce_start);
      end else if (busy && abort) begin
        abort_pend <= 1'b1;
      end
      case (state)
        S_START: wdog <= '0;
        S_WAIT: begin
          if (core_done) begin
            result_hash  <= core_hash;
            result_nonce <= nonce;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        S_CHECK: begin
          if (hash_count != 32'hFFFF_FFFF) hash_count <= hash_count + 32'd1;
          // Block for the next nonce is loaded here so it is valid during its START cycle.
          if (!hit && !abort_now && !last_nonce) begin
            nonce      <= nonce_nxt;
            core_block <= insert_nonce(tmpl, nonce_nxt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Bench for sha256_nonce_scheduler: fixed-latency fake core, directed and random sweeps against a sweep-level reference model.
module tb_sha256_nonce_scheduler;
  localparam int L  = 64;
  localparam int NL = 384;
  localparam int TO = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [511:0] cfg_template;
  logic [255:0] cfg_target;
  logic [31:0]  cfg_nonce_start;
  logic [31:0]  cfg_nonce_end;
  logic         abort;
  logic         core_start;
  logic [511:0] core_block;
  logic         core_done = 1'b0;
  logic [255:0] core_hash = '0;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic [31:0]  hash_count;

  sha256_nonce_scheduler #(.NONCE_LSB(NL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_template(cfg_template),
    .cfg_target(cfg_target), .cfg_nonce_start(cfg_nonce_start), .cfg_nonce_end(cfg_nonce_end),
    .abort(abort), .core_start(core_start), .core_block(core_block),
    .core_done(core_done), .core_hash(core_hash),
    .busy(busy), .found(found), .exhausted(exhausted), .timeout_err(timeout_err),
    .result_nonce(result_nonce), .result_hash(result_hash), .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Fake core: digest = {~nonce, 0}, L cycles after the start cycle.
  int           rem = 0;
  logic [31:0]  nf = '0;
  logic         core_en = 1'b1;
  logic         inject_done = 1'b0;
  logic [31:0]  started_q[$];
  int           start_cnt = 0;
  int           blk_bad = 0;
  logic [511:0] nmask = {480'h0, 32'hFFFF_FFFF} << NL;

  always @(negedge clk) begin
    core_done = inject_done;
    if (rem > 0) begin
      rem--;
      if (rem == 0 && core_en) begin
        core_done = 1'b1;
        core_hash = {~nf, 224'h0};
      end
    end
    if (core_start === 1'b1) begin
      rem = L;
      nf  = core_block[NL +: 32];
      started_q.push_back(nf);
      start_cnt++;
      if ((core_block & ~nmask) !== (cfg_template & ~nmask)) blk_bad++;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: walk the range by the sweep rules with plain arithmetic.
  logic [31:0]  exp_q[$];
  logic         e_found, e_exh;
  logic [31:0]  e_nonce;
  logic [255:0] e_hash;
  int           e_cnt;

  task automatic ref_sweep(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t,
                           input int abort_idx);
    logic [31:0] n;
    n = s; e_cnt = 0; e_found = 0; e_exh = 0;
    exp_q.delete();
    while (1) begin
      exp_q.push_back(n);
      e_cnt++;
      e_hash  = {~n, 224'h0};
      e_nonce = n;
      if (e_hash < t) begin e_found = 1; break; end
      if (abort_idx >= 0 && e_cnt == abort_idx + 1) break;
      if (n == e) begin e_exh = 1; break; end
      n = n + 32'd1;
    end
  endtask

  task automatic run_sweep(input string name, input logic [31:0] s, input logic [31:0] e,
                           input logic [255:0] t, input int abort_idx, input bit to_mode);
    int cyc, ab_wait, sc;
    bit ab_done, seq_ok;
    for (int i = 0; i < 16; i++) cfg_template[i*32 +: 32] = $urandom;
    cfg_target = t; cfg_nonce_start = s; cfg_nonce_end = e;
    ref_sweep(s, e, t, abort_idx);
    started_q.delete();
    start_cnt = 0; ab_wait = 0; ab_done = 0;
    chk({name, ".cfg_ready"}, cfg_ready, 1);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cyc = 1;
    chk({name, ".busy"}, busy, 1);
    while (busy === 1'b1 && cyc < 3000) begin
      abort = 1'b0;
      if (abort_idx >= 0 && start_cnt == abort_idx + 1 && !ab_done) begin
        ab_wait++;
        if (ab_wait == 10) begin abort = 1'b1; ab_done = 1; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0;
    if (to_mode) begin
      chk({name, ".cycles"}, cyc, TO + 2);
      chk({name, ".timeout_err"}, timeout_err, 1);
      chk({name, ".found"}, found, 0);
      chk({name, ".exhausted"}, exhausted, 0);
      chk({name, ".hash_count"}, hash_count, 0);
      chk({name, ".starts"}, start_cnt, 1);
    end else begin
      chk({name, ".cycles"}, cyc, e_cnt * (L + 2) + 1);
      chk({name, ".found"}, found, e_found);
      chk({name, ".exhausted"}, exhausted, e_exh);
      chk({name, ".timeout_err"}, timeout_err, 0);
      chk({name, ".hash_count"}, hash_count, e_cnt);
      chk({name, ".result_nonce"}, result_nonce, e_nonce);
      chk({name, ".result_hash"}, result_hash, e_hash);
      seq_ok = (started_q.size() == exp_q.size());
      if (seq_ok) foreach (exp_q[i]) if (started_q[i] !== exp_q[i]) seq_ok = 0;
      chk({name, ".nonce_seq"}, seq_ok, 1);
    end
    chk({name, ".cfg_ready_end"}, cfg_ready, 1);
    sc = start_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk({name, ".no_more_starts"}, start_cnt, sc);
  endtask

  logic [255:0] rt;
  logic [31:0]  rs;

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    cfg_template = '0; cfg_target = '0; cfg_nonce_start = '0; cfg_nonce_end = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.found", found, 0);
    chk("rst.core_start", core_start, 0);
    chk("rst.core_block_hi", core_block[511:256], 0);
    chk("rst.hash_count", hash_count, 0);
    chk("rst.result_hash", result_hash, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_sweep("hit", 32'd0, 32'd10, {32'hFFFF_FFF8, 224'h0}, -1, 0);
    chk("hit.nonce8", result_nonce, 32'd8);
    chk("hit.hash", result_hash, {32'hFFFF_FFF7, 224'h0});
    chk("hit.starts9", start_cnt, 9);

    run_sweep("wrap", 32'hFFFF_FFFE, 32'd1, 256'h0, -1, 0);
    chk("wrap.count4", hash_count, 4);

    core_en = 1'b0;
    run_sweep("tmo", 32'd5, 32'd9, 256'h0, -1, 1);
    core_en = 1'b1;

    run_sweep("after_tmo", 32'd3, 32'd6, {32'hFFFF_FFFB, 224'h1}, -1, 0);

    run_sweep("abort", 32'd0, 32'd100, 256'h0, 3, 0);
    chk("abort.count4", hash_count, 4);

    run_sweep("equal", 32'd0, 32'd0, {32'hFFFF_FFFF, 224'h0}, -1, 0);
    chk("equal.exhausted", exhausted, 1);

    for (int k = 0; k < 3; k++) begin
      rs = $urandom;
      rt[255:224] = ~(rs + 32'($urandom_range(0, 7)));
      for (int i = 0; i < 7; i++) rt[i*32 +: 32] = $urandom_range(0, 1);
      run_sweep($sformatf("rnd%0d", k), rs, rs + 32'($urandom_range(0, 5)), rt, -1, 0);
    end

    // Reset in the middle of WAIT; the core's digest then lands after reset.
    cfg_target = 256'h0; cfg_nonce_start = 32'd0; cfg_nonce_end = 32'd100;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst.busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.busy", busy, 0);
    chk("midrst.core_start", core_start, 0);
    chk("midrst.hash_count", hash_count, 0);
    chk("midrst.result_nonce", result_nonce, 0);
    chk("midrst.result_hash", result_hash, 0);
    chk("midrst.flags", {found, exhausted, timeout_err}, 0);
    repeat (60) @(posedge clk);
    #1;
    chk("late_done.busy", busy, 0);
    chk("late_done.cfg_ready", cfg_ready, 1);
    chk("late_done.hash_count", hash_count, 0);
    chk("late_done.result_hash", result_hash, 0);

    inject_done = 1'b1;
    @(posedge clk); #1;
    inject_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rest_done.busy", busy, 0);
    chk("rest_done.result_hash", result_hash, 0);

    chk("block_template_kept", blk_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_nonce_scheduler.md
Name: sha256_nonce_scheduler

Overview:
- Sequences one single-block SHA-256 core (512-bit block in, 256-bit digest out, start/done handshake) through a nonce sweep.
- Takes a configuration: padded 512-bit block template, nonce range and 256-bit target.
- For each nonce it inserts the nonce into the template, launches the core, waits for the digest and compares it against the target.
- Stops on the first hit, on range exhaustion, on abort, or on a core timeout. Sits between the host/CSR layer and the hash core in the miner.

Parameters:
- NONCE_LSB, 384, bit position of the nonce LSB in the 512-bit block; the nonce occupies [NONCE_LSB+31:NONCE_LSB]. Legal range 0..480.
- TIMEOUT_CYCLES, 128, maximum cycles in WAIT before the core is declared hung.

Ports:
- clk  in  1  single clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready
- cfg_template  in  512  padded message block
- cfg_target  in  256  success threshold
- cfg_nonce_start  in  32  first nonce
- cfg_nonce_end  in  32  last nonce, inclusive
- abort  in  1  stop sweep
- core_start  out  1  one-cycle launch pulse to the core
- core_block  out  512  block to hash; registered, stable from START until the next START
- core_done  in  1  one-cycle pulse; core_hash valid in the same cycle
- core_hash  in  256  digest, bit 255 = MSB
- busy  out  1  sweep in progress
- found  out  1  sweep ended with a hit
- exhausted  out  1  range ended without a hit
- timeout_err  out  1  core failed to respond
- result_nonce  out  32  last nonce hashed (hit nonce when found)
- result_hash  out  256  last digest captured
- hash_count  out  32  digests checked in the current sweep

Behaviour:
- Reset: all outputs 0, state IDLE, nonce register 0. Reset mid-sweep aborts immediately. Any core_done arriving after reset is ignored.
- States:
  - IDLE, FOUND, EXHAUSTED, TERR are the rest states; cfg_ready=1 only in these, busy=0.
  - START, WAIT, CHECK are active; busy=1.
- Rest states: on cfg_valid && cfg_ready, latch all cfg_* fields, set nonce=cfg_nonce_start, clear found/exhausted/timeout_err/hash_count, go to START. Status outputs hold until then.
- START (1 cycle):
  - core_start=1.
  - core_block = template with the nonce field replaced; written on entry, so it is valid while core_start=1.
  - Clear the watchdog. Next state is WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On core_done: capture core_hash into result_hash, set result_nonce=nonce, go to CHECK.
  - If the watchdog reaches TIMEOUT_CYCLES without core_done, go to TERR with timeout_err=1.
  - core_done in the same cycle as expiry: done wins.
- CHECK (1 cycle): increment hash_count (saturating at 32'hFFFFFFFF), then take the first matching branch:
  - result_hash < target, unsigned 256-bit compare: go to FOUND, found=1.
  - Abort pending: go to IDLE, status flags remain 0.
  - nonce == nonce_end: go to EXHAUSTED, exhausted=1.
  - Otherwise: nonce = nonce+1, wrapping FFFFFFFF→0, then go to START. start > end therefore sweeps through the wrap.
- Abort:
  - Sampled in any active state and latched into a pending flag.
  - Never cuts the core off mid-hash: the in-flight digest is still captured and checked, so a hit still reports found.
  - A timeout while abort is pending still goes to TERR.
  - Abort in a rest state is ignored.
- core_done outside WAIT is ignored.
- Throughput: with core latency L (cycles from the core_start cycle to the core_done cycle), each nonce costs L+2 cycles.

Test Plan:
- Bench core model: returns done L=64 cycles after start, with hash = {~nonce_field, 224'h0}.
- Hit: start=0, end=10, target={32'hFFFFFFF8,224'h0} -> found=1, result_nonce=8, result_hash={32'hFFFFFFF7,224'h0}, hash_count=9, busy low at cycle 9×66+1 after accept; core_start pulsed exactly 9 times.
- Exhaust with wrap: target=0, start=FFFFFFFE, end=1 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 hashed; exhausted=1, result_nonce=1, hash_count=4, found=0.
- Timeout: model never asserts done -> timeout_err=1 after 128 WAIT cycles, busy=0, hash_count=0, cfg_ready=1; a fresh cfg is then accepted normally.
- Abort: target=0, start=0, end=100, abort pulsed during WAIT of nonce 3 -> that digest is checked, then IDLE; hash_count=4, all flags 0, no further core_start.
- Reset and boundaries:
  - reset asserted mid-WAIT -> next cycle all outputs 0.
  - A late core_done is ignored and cfg_ready=1.
  - Hash equal to target is not a hit: target={32'hFFFFFFFF,224'h0}, start=end=0 -> exhausted=1.
